ser_word_collector: RTL and testbench

- Serial-to-parallel stage directly downstream of the 110101 detector/counter FSM.
- Consumes the detector's serial payload (serOut/serOutValid) and packs it into WIDTH-bit words.
- Presents each word on a valid/ready parallel port with a bit-length tag.
- Flags frame end and output overflow for the lab top level (LEDs / 7-seg).

---
 rtl/ser_word_collector.sv | 136 +++++++++++++
 tb/tb_ser_word_collector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ser_word_collector.sv
// ser_word_collector: packs the detector's serial payload into WIDTH-bit words.
// A single-entry output buffer presents each word with its bit length on a
// valid/ready port. frameDone pulses once per payload frame, and overflow is
// a sticky flag set when a completed word has to be dropped.
module ser_word_collector #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Clk_EN,
  input  logic             serIn,
  input  logic             serInValid,
  input  logic             parReady,
  output logic [WIDTH-1:0] parOut,
  output logic [LEN_W-1:0] parLen,
  output logic             parValid,
  output logic             frameDone,
  output logic             overflow
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);

  state_t           state_p0;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_p0;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] shifted;
  logic [LEN_W-1:0] cnt_p0;
  logic [LEN_W-1:0] cnt_nxt;
  logic [LEN_W-1:0] cnt_inc;
  logic             commit;
  logic [WIDTH-1:0] commit_word;
  logic [LEN_W-1:0] commit_len;
  logic             done_nxt;
  logic             load;

  assign shifted = {shift_p0[WIDTH-2:0], serIn};
  assign cnt_inc = cnt_p0 + LEN_W'(1);

  // Next-state logic: collection only advances on enabled edges
  always_comb begin
    state_nxt   = state_p0;
    shift_nxt   = shift_p0;
    cnt_nxt     = cnt_p0;
    commit      = 1'b0;
    commit_word = '0;
    commit_len  = '0;
    done_nxt    = 1'b0;
    if (Clk_EN) begin
      case (state_p0)
        IDLE: begin
          if (serInValid) begin
            shift_nxt = {{(WIDTH-1){1'b0}}, serIn};
            cnt_nxt   = LEN_W'(1);
            state_nxt = COLLECT;
          end
        end
        COLLECT: begin
          if (serInValid) begin
            if (cnt_inc == FULL_LEN) begin
              // Full word: hand it off and restart from an empty register
              commit      = 1'b1;
              commit_word = shifted;
              commit_len  = FULL_LEN;
              shift_nxt   = '0;
              cnt_nxt     = '0;
            end else begin
              shift_nxt = shifted;
              cnt_nxt   = cnt_inc;
            end
          end else begin
            // Frame end: flush any partial word (upper bits already zero)
            if (cnt_p0 != '0) begin
              commit      = 1'b1;
              commit_word = shift_p0;
              commit_len  = cnt_p0;
            end
            done_nxt  = 1'b1;
            shift_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A committed word enters the buffer if it is empty or being drained now
  assign load = commit & (~parValid | parReady);

  // ---- stage p0: collection state ----
  // Collection state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      shift_p0 <= '0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      shift_p0 <= shift_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

  // ---- stage p1: output buffer and status flags ----
  // Output buffer, frame-end pulse and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      parOut    <= '0;
      parLen    <= '0;
      parValid  <= 1'b0;
      frameDone <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frameDone <= done_nxt;
      if (load) begin
        parOut   <= commit_word;
        parLen   <= commit_len;
        parValid <= 1'b1;
      end else if (parValid && parReady) begin
        parValid <= 1'b0;
      end
      if (commit && parValid && !parReady) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ser_word_collector.sv
// Bench for ser_word_collector: scoreboard of expected words popped on each
// handshake, plus per-scenario inline checks of flags and buffer contents.
module tb_ser_word_collector;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic [LEN_W-1:0] len;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             Clk_EN = 1'b0;
  logic             serIn = 1'b0;
  logic             serInValid = 1'b0;
  logic             parReady = 1'b0;
  logic [WIDTH-1:0] parOut;
  logic [LEN_W-1:0] parLen;
  logic             parValid;
  logic             frameDone;
  logic             overflow;

  int   checks = 0;
  int   failures = 0;
  int   fd_count = 0;
  exp_t sb[$];

  ser_word_collector #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .Clk_EN(Clk_EN), .serIn(serIn),
    .serInValid(serInValid), .parReady(parReady), .parOut(parOut),
    .parLen(parLen), .parValid(parValid), .frameDone(frameDone),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard: a word transfers on the next edge when valid and ready are both high
  always @(negedge clk) begin
    if (frameDone) fd_count++;
    if (!rst && parValid && parReady) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_word: got parOut=%h parLen=%0d, required no word", parOut, parLen);
      end else begin
        e = sb.pop_front();
        if (parOut !== e.word || parLen !== e.len) begin
          failures++;
          $display("FAIL sb_word: got %h/len %0d, required %h/len %0d", parOut, parLen, e.word, e.len);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v, input logic b);
    Clk_EN = 1'b1;
    serInValid = v;
    serIn = b;
    tick();
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(1'b1, bits[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (parOut !== 8'h00)  begin failures++; $display("FAIL reset_parOut: got %h required 00", parOut); end
    checks++; if (parLen !== 4'd0)   begin failures++; $display("FAIL reset_parLen: got %0d required 0", parLen); end
    checks++; if (parValid !== 1'b0) begin failures++; $display("FAIL reset_parValid: got %b required 0", parValid); end
    checks++; if (frameDone !== 1'b0) begin failures++; $display("FAIL reset_frameDone: got %b required 0", frameDone); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b required 0", overflow); end
  endtask

  task automatic test_single_word();
    int fd0;
    fd0 = fd_count;
    parReady = 1'b1;
    send_bits(16'h0059, 7);  // 1011001
    checks++; if (parValid !== 1'b0) begin failures++; $display("FAIL t1_early_valid: got %b required 0", parValid); end
    sb.push_back('{word: 8'hB2, len: 4'd8});
    send_bit(1'b1, 1'b0);
    checks++; if (parValid !== 1'b1 || parOut !== 8'hB2 || parLen !== 4'd8) begin
      failures++; $display("FAIL t1_word: got v=%b %h/%0d required v=1 b2/8", parValid, parOut, parLen);
    end
    send_bit(1'b0, 1'b0);
    checks++; if (frameDone !== 1'b1) begin failures++; $display("FAIL t1_frameDone: got %b required 1", frameDone); end
    checks++; if (parValid !== 1'b0) begin failures++; $display("FAIL t1_no_second_word: got %b required 0", parValid); end
    send_bit(1'b0, 1'b0);
    checks++; if (frameDone !== 1'b0) begin failures++; $display("FAIL t1_frameDone_width: got %b required 0", frameDone); end
    tick();
    checks++; if (fd_count - fd0 !== 1) begin failures++; $display("FAIL t1_fd_count: got %0d required 1", fd_count - fd0); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL t1_sb_left: got %0d required 0", sb.size()); end
  endtask

  task automatic test_partial_word();
    int fd0;
    fd0 = fd_count;
    parReady = 1'b1;
    sb.push_back('{word: 8'hB2, len: 4'd8});
    sb.push_back('{word: 8'h05, len: 4'd3});
    send_bits(16'h0595, 11);
    send_bit(1'b0, 1'b0);
    checks++; if (parValid !== 1'b1 || parOut !== 8'h05 || parLen !== 4'd3) begin
      failures++; $display("FAIL t2_partial: got v=%b %h/%0d required v=1 05/3", parValid, parOut, parLen);
    end
    checks++; if (frameDone !== 1'b1) begin failures++; $display("FAIL t2_frameDone: got %b required 1", frameDone); end
    send_bit(1'b0, 1'b0);
    tick();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL t2_overflow: got %b required 0", overflow); end
    checks++; if (fd_count - fd0 !== 1) begin failures++; $display("FAIL t2_fd_count: got %0d required 1", fd_count - fd0); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL t2_sb_left: got %0d required 0", sb.size()); end
  endtask

  task automatic slow_bit(input logic v, input logic b);
    for (int k = 0; k < 2; k++) begin
      Clk_EN = 1'b0;
      serInValid = 1'($urandom_range(0, 1));
      serIn = 1'($urandom_range(0, 1));
      tick();
    end
    send_bit(v, b);
  endtask

  task automatic test_clk_enable();
    int fd0;
    logic [15:0] bits;
    fd0 = fd_count;
    bits = 16'h0595;
    parReady = 1'b1;
    sb.push_back('{word: 8'hB2, len: 4'd8});
    sb.push_back('{word: 8'h05, len: 4'd3});
    for (int i = 10; i >= 0; i--) slow_bit(1'b1, bits[i]);
    slow_bit(1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      Clk_EN = 1'b0;
      serInValid = 1'($urandom_range(0, 1));
      serIn = 1'($urandom_range(0, 1));
      tick();
    end
    serInValid = 1'b0;
    checks++; if (fd_count - fd0 !== 1) begin failures++; $display("FAIL t3_fd_count: got %0d required 1", fd_count - fd0); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL t3_sb_left: got %0d required 0", sb.size()); end
    checks++; if (parValid !== 1'b0) begin failures++; $display("FAIL t3_idle_valid: got %b required 0", parValid); end
  endtask

  task automatic test_overflow();
    parReady = 1'b0;
    sb.push_back('{word: 8'hB2, len: 4'd8});
    send_bits(16'hB23C, 16);
    send_bit(1'b0, 1'b0);
    checks++; if (parValid !== 1'b1 || parOut !== 8'hB2 || parLen !== 4'd8) begin
      failures++; $display("FAIL t4_hold: got v=%b %h/%0d required v=1 b2/8", parValid, parOut, parLen);
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL t4_overflow_set: got %b required 1", overflow); end
    parReady = 1'b1;
    send_bit(1'b0, 1'b0);
    checks++; if (parValid !== 1'b0) begin failures++; $display("FAIL t4_drain: got %b required 0", parValid); end
    tick();
    tick();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL t4_overflow_sticky: got %b required 1", overflow); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL t4_sb_left: got %0d required 0", sb.size()); end
  endtask

  task automatic test_mid_frame_reset();
    parReady = 1'b1;
    send_bits(16'h001B, 5);
    rst = 1'b1;
    send_bit(1'b1, 1'b1);
    rst = 1'b0;
    checks++; if (parOut !== 8'h00 || parLen !== 4'd0 || parValid !== 1'b0 || frameDone !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL t5_reset: got %h/%0d v=%b fd=%b ov=%b required 00/0 v=0 fd=0 ov=0", parOut, parLen, parValid, frameDone, overflow);
    end
    sb.push_back('{word: 8'hA5, len: 4'd8});
    send_bits(16'h00A5, 8);
    checks++; if (parValid !== 1'b1 || parOut !== 8'hA5 || parLen !== 4'd8) begin
      failures++; $display("FAIL t5_clean_word: got v=%b %h/%0d required v=1 a5/8", parValid, parOut, parLen);
    end
    send_bit(1'b0, 1'b0);
    tick();
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL t5_sb_left: got %0d required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    parReady = 1'b0;
    sb.push_back('{word: 8'h3C, len: 4'd8});
    send_bits(16'h003C, 8);
    send_bits(16'h004B, 7);  // top seven bits of 0x96
    checks++; if (parValid !== 1'b1 || parOut !== 8'h3C) begin
      failures++; $display("FAIL t6_first: got v=%b %h required v=1 3c", parValid, parOut);
    end
    sb.push_back('{word: 8'h96, len: 4'd8});
    parReady = 1'b1;
    send_bit(1'b1, 1'b0);
    checks++; if (parValid !== 1'b1 || parOut !== 8'h96 || parLen !== 4'd8) begin
      failures++; $display("FAIL t6_reload: got v=%b %h/%0d required v=1 96/8", parValid, parOut, parLen);
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL t6_overflow: got %b required 0", overflow); end
    send_bit(1'b0, 1'b0);
    checks++; if (parValid !== 1'b0) begin failures++; $display("FAIL t6_drain: got %b required 0", parValid); end
    tick();
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL t6_sb_left: got %0d required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_partial_word();
    test_clk_enable();
    test_overflow();
    test_mid_frame_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
